// File: rtl/event_ts_pkg.sv
// Shared definitions for the event timestamper slice.
//   TS_WIDTH      default width of captured counts and deltas
//   ts_entry_t    one FIFO entry: captured count plus delta to previous event
//   MIN_DEPTH     smallest legal FIFO depth
//   depth_is_legal  true when a depth is a power of two and >= MIN_DEPTH
package event_ts_pkg;

  localparam int unsigned TS_WIDTH  = 32;
  localparam int unsigned MIN_DEPTH = 2;

  typedef struct packed {
    logic [TS_WIDTH-1:0] count;
    logic [TS_WIDTH-1:0] delta;
  } ts_entry_t;

  function automatic bit depth_is_legal(input int unsigned depth);
    return (depth >= MIN_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/event_timestamper_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst      clock and synchronous active-high reset (empties the FIFO)
//   push, din     write request and data; a push while full is accepted only
//                 when a pop happens in the same cycle
//   pop           read request; ignored while empty
//   dout          head entry, valid whenever empty=0
//   full, empty   registered status flags
//   level         registered occupancy, 0..DEPTH
module sync_fifo
  import event_ts_pkg::*;
#(
  parameter type         T     = ts_entry_t,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  T            mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic        empty_q, empty_d;
  logic        full_q, full_d;
  logic        do_push, do_pop;

  always_comb begin
    do_pop   = pop && !empty_q;
    // When full, the slot being written is the head being popped this cycle;
    // the head is read before the edge, so the overwrite is safe.
    do_push  = push && (!full_q || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (do_pop && !do_push) begin
      level_d = level_q - 1'b1;
    end
    empty_d = (level_d == '0);
    full_d  = (level_d == FULL_LVL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule

// File: rtl/event_timestamper.sv
// Timestamps rising edges of a synchronous event line against a free-running
// counter and queues (count, delta) pairs for a valid/ready consumer.
//   clk, rst   clock, synchronous active-high reset
//   count_in   counter value in the clk domain
//   evt_in     synchronous event level; a 0->1 transition is one event
//   ts_ready   consumer accepts the head entry
//   clr_ovf    clears overflow, drop_cnt and the delta reference
//   ts_valid   FIFO holds at least one entry
//   ts_count   head entry captured count
//   ts_delta   head entry delta to previous accepted event (mod 2^WIDTH)
//   level      FIFO occupancy
//   overflow   sticky: an event was dropped
//   drop_cnt   saturating count of dropped events
module event_timestamper
  import event_ts_pkg::*;
#(
  parameter int unsigned WIDTH  = TS_WIDTH,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       count_in,
  input  logic                   evt_in,
  input  logic                   ts_ready,
  input  logic                   clr_ovf,
  output logic                   ts_valid,
  output logic [WIDTH-1:0]       ts_count,
  output logic [WIDTH-1:0]       ts_delta,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt
);

  if (!depth_is_legal(DEPTH)) begin : g_bad_depth
    $error("event_timestamper: DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] delta;
  } entry_t;

  logic              evt_q, evt_d;
  logic              have_last_q, have_last_d;
  logic [WIDTH-1:0]  last_count_q, last_count_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic   evt_edge, pop, dropped, accepted;
  logic   fifo_full, fifo_empty;
  entry_t push_entry, head_entry;

  always_comb begin
    evt_edge = evt_in && !evt_q;
    pop      = !fifo_empty && ts_ready;
    dropped  = evt_edge && fifo_full && !pop;
    accepted = evt_edge && !dropped;

    push_entry.count = count_in;
    // clr_ovf in the event cycle drops the reference, so the delta is 0.
    push_entry.delta = (have_last_q && !clr_ovf) ? (count_in - last_count_q) : '0;

    evt_d        = evt_in;
    last_count_d = accepted ? count_in : last_count_q;

    have_last_d = have_last_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    if (clr_ovf) begin
      have_last_d = 1'b0;
      overflow_d  = 1'b0;
      drop_cnt_d  = '0;
    end
    // The event wins over a simultaneous clear.
    if (accepted) begin
      have_last_d = 1'b1;
    end
    if (dropped) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != '1) begin
        drop_cnt_d = drop_cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q        <= 1'b1;
      have_last_q  <= 1'b0;
      last_count_q <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      evt_q        <= evt_d;
      have_last_q  <= have_last_d;
      last_count_q <= last_count_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt_edge),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign ts_valid = !fifo_empty;
  assign ts_count = head_entry.count;
  assign ts_delta = head_entry.delta;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_event_timestamper.sv
module tb_event_timestamper;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned DROP_W   = 8;
  localparam int unsigned DROP_MAX = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  count_in;
  logic              evt_in;
  logic              ts_ready;
  logic              clr_ovf;
  logic              ts_valid;
  logic [WIDTH-1:0]  ts_count;
  logic [WIDTH-1:0]  ts_delta;
  logic [3:0]        level;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  event_timestamper #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .evt_in   (evt_in),
    .ts_ready (ts_ready),
    .clr_ovf  (clr_ovf),
    .ts_valid (ts_valid),
    .ts_count (ts_count),
    .ts_delta (ts_delta),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of (count, delta) pairs plus the flags.
  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] delta;
  } m_entry_t;

  m_entry_t    mq[$];
  logic        m_prev_evt;
  logic        m_have;
  logic [WIDTH-1:0] m_last;
  logic        m_ovf;
  int unsigned m_drop;
  bit          m_init = 0;

  always @(posedge clk) begin
    bit       ev, pop, room;
    m_entry_t e;
    if (rst) begin
      mq.delete();
      m_prev_evt = 1'b1;
      m_have     = 1'b0;
      m_last     = '0;
      m_ovf      = 1'b0;
      m_drop     = 0;
      m_init     = 1;
    end else if (m_init) begin
      ev   = evt_in && !m_prev_evt;
      pop  = (mq.size() != 0) && ts_ready;
      room = (mq.size() < DEPTH) || pop;
      if (pop) e = mq.pop_front();
      if (clr_ovf) begin
        m_ovf  = 1'b0;
        m_drop = 0;
        m_have = 1'b0;
      end
      if (ev) begin
        if (room) begin
          e.count = count_in;
          e.delta = m_have ? count_in - m_last : '0;
          mq.push_back(e);
          m_last = count_in;
          m_have = 1'b1;
        end else begin
          m_ovf = 1'b1;
          if (m_drop < DROP_MAX) m_drop++;
        end
      end
      m_prev_evt = evt_in;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("valid", ts_valid, (mq.size() != 0));
      check("level", level, mq.size());
      check("overflow", overflow, m_ovf);
      check("drop_cnt", drop_cnt, m_drop);
      if (mq.size() != 0) begin
        check("head_count", ts_count, mq[0].count);
        check("head_delta", ts_delta, mq[0].delta);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ev(input logic [WIDTH-1:0] c);
    evt_in   = 1'b1;
    count_in = c;
    tick();
    evt_in = 1'b0;
    tick();
  endtask

  initial begin
    rst      = 1'b1;
    evt_in   = 1'b1;
    count_in = '0;
    ts_ready = 1'b0;
    clr_ovf  = 1'b0;
    repeat (3) tick();
    check("rst_valid", ts_valid, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);

    // evt_in held high through reset release: no event
    rst = 1'b0;
    repeat (3) tick();
    check("hold_high_no_evt", level, 0);
    evt_in = 1'b0;
    tick();

    // basic capture
    ts_ready = 1'b1;
    evt_in = 1'b1; count_in = 100;
    check("basic1_pre_valid", ts_valid, 0);
    tick();
    check("basic1_valid", ts_valid, 1);
    check("basic1_count", ts_count, 100);
    check("basic1_delta", ts_delta, 0);
    evt_in = 1'b0;
    tick();
    evt_in = 1'b1; count_in = 250;
    check("basic2_pre_valid", ts_valid, 0);
    tick();
    check("basic2_valid", ts_valid, 1);
    check("basic2_count", ts_count, 250);
    check("basic2_delta", ts_delta, 150);
    evt_in = 1'b0;
    tick();

    // counter wrap
    ev(32'hFFFF_FFF0);
    evt_in = 1'b1; count_in = 32'h0000_0010;
    tick();
    check("wrap_delta", ts_delta, 32'h20);
    evt_in = 1'b0;
    tick();

    // overflow
    ts_ready = 1'b0;
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    for (int i = 1; i <= 10; i++) ev(32'(i * 10));
    check("ovf_level", level, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_drop", drop_cnt, 2);
    ts_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_count", ts_count, 64'((i + 1) * 10));
      check("drain_delta", ts_delta, (i == 0) ? 64'd0 : 64'd10);
      tick();
    end
    ts_ready = 1'b0;
    check("drained_level", level, 0);
    ev(110);
    check("gap_count", ts_count, 110);
    check("gap_delta", ts_delta, 30);
    ts_ready = 1'b1; tick(); ts_ready = 1'b0;
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("clr_ovf_flag", overflow, 0);
    check("clr_ovf_drop", drop_cnt, 0);

    // full FIFO with simultaneous pop
    for (int i = 2; i <= 9; i++) ev(32'(i * 100));
    check("full_level", level, 8);
    evt_in = 1'b1; count_in = 1000; ts_ready = 1'b1;
    tick();
    evt_in = 1'b0; ts_ready = 1'b0;
    check("fullpop_level", level, 8);
    check("fullpop_ovf", overflow, 0);
    check("fullpop_drop", drop_cnt, 0);
    check("fullpop_head", ts_count, 300);
    ts_ready = 1'b1;
    repeat (7) tick();
    check("tail_count", ts_count, 1000);
    check("tail_delta", ts_delta, 100);
    tick();
    ts_ready = 1'b0;
    check("tail_popped", level, 0);

    // reset with entries buffered
    for (int i = 1; i <= 5; i++) ev(32'(2000 + i));
    check("pre_rst_level", level, 5);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_level", level, 0);
    check("mid_rst_valid", ts_valid, 0);
    tick();
    ev(5000);
    check("post_rst_count", ts_count, 5000);
    check("post_rst_delta", ts_delta, 0);

    // drop counter saturation: 7 more fill the FIFO, then 300 dropped
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    for (int i = 0; i < 307; i++) ev(32'(6000 + i));
    check("sat_level", level, 8);
    check("sat_ovf", overflow, 1);
    check("sat_drop", drop_cnt, 255);

    ts_ready = 1'b1;
    repeat (12) tick();
    check("final_level", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
